// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: paces set/clear requests into non-overlapping S/R pulses with a one-entry pending slot
module sr_cmd_sequencer #(
  parameter int PULSE_W  = 2,
  parameter int GAP_W    = 1,
  parameter int CLR_WINS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_req,
  input  logic       clr_req,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       conflict,
  output logic       dropped,
  output logic       q_model,
  output logic [7:0] cmd_count
);
  typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} state_t;
  localparam logic [3:0] PW_M1 = 4'(PULSE_W - 1);
  localparam logic [3:0] GW_M1 = 4'(GAP_W - 1);
  state_t     r_state, w_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_pend_v, r_pend_t, w_pv_nxt, w_pt_nxt;
  logic       r_s, r_r, r_busy, r_conflict, r_dropped, r_q;
  logic [7:0] r_count;
  logic       w_req_v, w_req_t, w_both, w_mv, w_mt, w_end, w_leave;
  assign w_both  = set_req & clr_req;
  assign w_req_v = set_req | clr_req;
  assign w_req_t = w_both ? (CLR_WINS == 0) : set_req;
  // the freshest request always replaces whatever is pending
  assign w_mv    = w_req_v | r_pend_v;
  assign w_mt    = w_req_v ? w_req_t : r_pend_t;
  assign w_end   = (r_state == SET_P || r_state == CLR_P) && r_cnt == 4'd0;
  assign w_leave = r_state == IDLE || (r_state == GAP && r_cnt == 4'd0) || (w_end && GAP_W == 0);
  always_comb begin
    w_nxt    = r_state;
    w_pv_nxt = w_mv;
    w_pt_nxt = w_mt;
    if (w_leave) begin
      w_nxt    = w_mv ? (w_mt ? SET_P : CLR_P) : IDLE;
      w_pv_nxt = 1'b0;
    end else if (w_end) begin
      w_nxt = GAP;
    end
    w_cnt_nxt = (w_leave || w_end) ? (w_nxt == GAP ? GW_M1 : PW_M1) : r_cnt - 4'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_pend_v   <= 1'b0;
      r_pend_t   <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
      r_dropped  <= 1'b0;
      r_q        <= 1'b0;
      r_count    <= 8'd0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend_v   <= w_pv_nxt;
      r_pend_t   <= w_pt_nxt;
      r_s        <= w_nxt == SET_P;
      r_r        <= w_nxt == CLR_P;
      r_busy     <= w_nxt != IDLE;
      r_conflict <= w_both;
      r_dropped  <= w_both | (w_req_v & r_pend_v);
      if (w_end) begin
        r_q <= r_state == SET_P;
        if (r_count != 8'hFF) r_count <= r_count + 8'd1;
      end
    end
  end
  assign s         = r_s;
  assign r         = r_r;
  assign busy      = r_busy;
  assign conflict  = r_conflict;
  assign dropped   = r_dropped;
  assign q_model   = r_q;
  assign cmd_count = r_count;
endmodule
